wb_master_arbiter: RTL and testbench
====================================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 Parameter WB_DATA, 32, Wishbone data and address width.
REQ-002 Parameter TIMEOUT, 255, maximum cycles a granted transfer may wait for ack/err/rty; legal range 1..255.
REQ-003 Port wb_clk, input, 1, the only clock.
REQ-004 Port wb_rst, input, 1, reset; synchronous, active-high.
REQ-005 Ports mN_cyc_i / mN_stb_i / mN_we_i (N=0 boot master, N=1 CPU master), input, 1 each, master request strobes.
REQ-006 Ports mN_adr_i / mN_dat_i, input, WB_DATA each, master address and write data.
REQ-007 Ports mN_sel_i / mN_cti_i / mN_bte_i, input, WB_DATA/8 / 3 / 2, master byte select and burst fields.
REQ-008 Ports mN_ack_o / mN_err_o / mN_rty_o, output, 1 each, per-master termination.
REQ-009 Port mN_dat_o, output, WB_DATA, read data returned to master N.
REQ-010 Ports s_cyc_o / s_stb_o / s_we_o / s_adr_o / s_dat_o / s_sel_o / s_cti_o / s_bte_o, output, widths as master fields, shared slave bus.
REQ-011 Ports s_ack_i / s_err_i / s_rty_i / s_dat_i, input, 1/1/1/WB_DATA, slave response.
REQ-012 Port grant, output, 2, one-hot current owner (01=m0, 10=m1, 00=none).
REQ-013 Port timeout_evt, output, 1, single-cycle pulse when the watchdog aborts a transfer.

Function
REQ-014 FSM states SHALL be IDLE, GRANT0, GRANT1, ABORT.
REQ-015 In IDLE, s_cyc_o, s_stb_o and all s_* fields SHALL be driven 0, and grant SHALL be 00.
REQ-016 From IDLE with exactly one mN_cyc_i high, the FSM SHALL enter GRANTN on the next edge.
REQ-017 From IDLE with both cyc high, the grant SHALL go to the master not served last (round-robin); after reset the m0 (boot) master wins first.
REQ-018 In GRANTN, the s_* outputs SHALL combinationally equal the mN_* inputs.
REQ-019 In GRANTN, s_ack_i/s_err_i/s_rty_i/s_dat_i SHALL be routed combinationally to master N only.
REQ-020 The non-granted master's ack/err/rty SHALL be 0 at all times.
REQ-021 In GRANTN, the grant SHALL be held while mN_cyc_i=1, across multiple stb beats and bursts.
REQ-022 When mN_cyc_i drops in GRANTN, the FSM SHALL return to IDLE the next edge and record N as last-served.
REQ-023 Regrant latency SHALL be one idle cycle minimum: no back-to-back handover without passing through IDLE.
REQ-024 An 8-bit watchdog counter SHALL clear on entry to GRANTN and on any s_ack_i/s_err_i/s_rty_i.
REQ-025 The watchdog SHALL increment each cycle in GRANTN while s_stb_o=1 and no termination is present; it SHALL NOT wrap.
REQ-026 When the watchdog reaches TIMEOUT, the FSM SHALL enter ABORT.
REQ-027 ABORT SHALL last exactly one cycle and SHALL drive s_cyc_o=0, mN_err_o=1 for the owner, and timeout_evt=1.
REQ-028 ABORT SHALL exit to IDLE, recording the aborted master as last-served.
REQ-029 If the owner drops cyc in the same cycle the watchdog reaches TIMEOUT, cyc drop SHALL win: go to IDLE, no err, no timeout_evt.
REQ-030 A slave termination arriving in the TIMEOUT cycle SHALL be forwarded and SHALL cancel the abort.
REQ-031 mN_dat_o SHALL equal s_dat_i when N is granted, else 0.

Reset
REQ-032 With wb_rst high at a wb_clk edge, state SHALL become IDLE, the watchdog 0, last-served m1 (so m0 wins first), and timeout_evt 0.
REQ-033 Reset asserted mid-transfer SHALL drop s_cyc_o in the following cycle with no termination sent to either master.
REQ-034 Outputs during and immediately after reset SHALL be all zero.

Verification
REQ-035 m0 only: cyc/stb write to 0x92000002 with data 0x5, slave acks after 3 cycles -> grant=01 one cycle after cyc, m0_ack_o pulse, m1 outputs 0.
REQ-036 Both masters: cyc raised same cycle after reset -> m0 served first; after m0 drops cyc, one IDLE cycle, then grant=10; repeat simultaneous request -> m0 again.
REQ-037 m1 burst of 4 stb beats with cyc held -> grant stays 10 throughout; m0 request pending gets nothing until m1 drops cyc.
REQ-038 TIMEOUT=8, slave never responds -> after 8 stalled cycles one-cycle m0_err_o=1 with timeout_evt=1, s_cyc_o=0, then IDLE.
REQ-039 Slave acks in the exact TIMEOUT cycle -> ack forwarded, no err, no timeout_evt.
REQ-040 wb_rst pulsed while grant=10 mid-burst -> next cycle grant=00, s_cyc_o=0, no ack/err/rty to m1.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter with round-robin grant and a per-transfer watchdog.
// Master 0 is the boot master and master 1 is the CPU. Both share one slave bus.
// The owner keeps the bus for as long as it holds cyc. A transfer that stalls too
// long is aborted with an err to its owner.
module wb_master_arbiter #(
  parameter int unsigned WB_DATA = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  // master 0 (boot)
  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_we_i,
  input  logic [WB_DATA-1:0]     m0_adr_i,
  input  logic [WB_DATA-1:0]     m0_dat_i,
  input  logic [WB_DATA/8-1:0]   m0_sel_i,
  input  logic [2:0]             m0_cti_i,
  input  logic [1:0]             m0_bte_i,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,
  output logic                   m0_rty_o,
  output logic [WB_DATA-1:0]     m0_dat_o,
  // master 1 (CPU)
  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_we_i,
  input  logic [WB_DATA-1:0]     m1_adr_i,
  input  logic [WB_DATA-1:0]     m1_dat_i,
  input  logic [WB_DATA/8-1:0]   m1_sel_i,
  input  logic [2:0]             m1_cti_i,
  input  logic [1:0]             m1_bte_i,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,
  output logic                   m1_rty_o,
  output logic [WB_DATA-1:0]     m1_dat_o,
  // shared slave bus
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [WB_DATA-1:0]     s_adr_o,
  output logic [WB_DATA-1:0]     s_dat_o,
  output logic [WB_DATA/8-1:0]   s_sel_o,
  output logic [2:0]             s_cti_o,
  output logic [1:0]             s_bte_o,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  input  logic                   s_rty_i,
  input  logic [WB_DATA-1:0]     s_dat_i,
  // status
  output logic [1:0]             grant,
  output logic                   timeout_evt
);

  // The abort fires on the stalled cycle that would take the watchdog to TIMEOUT.
  localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);
  localparam logic [7:0] WdogMax  = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StGrant0,
    StGrant1,
    StAbort
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wdog_q, wdog_d;
  logic       last_q, last_d;    // 1: master 1 was served last
  logic       owner_q, owner_d;  // master holding the bus in GRANT/ABORT
  logic [1:0] grant_q, grant_d;
  logic       tevt_q, tevt_d;

  logic own_cyc;
  logic own_stb;
  logic s_term;
  logic bus_en;
  logic sel_m0;
  logic sel_m1;
  logic abort_act;

  assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner_q ? m1_stb_i : m0_stb_i;
  assign s_term  = s_ack_i | s_err_i | s_rty_i;

  // Outputs are forced quiet while reset is held so nothing leaks mid-transfer.
  assign bus_en    = ~wb_rst;
  assign sel_m0    = bus_en & (state_q == StGrant0);
  assign sel_m1    = bus_en & (state_q == StGrant1);
  assign abort_act = bus_en & (state_q == StAbort);

  // Next-state: arbitration, hold-while-cyc, watchdog and abort sequencing.
  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    last_d  = last_q;
    owner_d = owner_q;
    case (state_q)
      StIdle: begin
        if (m0_cyc_i || m1_cyc_i) begin
          // m1 wins if it is alone, or if both ask and m0 was served last.
          owner_d = m1_cyc_i & (~m0_cyc_i | ~last_q);
          state_d = owner_d ? StGrant1 : StGrant0;
          wdog_d  = '0;
        end
      end
      StGrant0, StGrant1: begin
        if (!own_cyc) begin
          // Cycle release wins over a coincident watchdog expiry.
          state_d = StIdle;
          last_d  = owner_q;
        end else if (s_term) begin
          // Any termination, even in the expiry cycle, restarts the watchdog.
          wdog_d = '0;
        end else if (own_stb) begin
          if (wdog_q == WdogLast) begin
            state_d = StAbort;
          end else if (wdog_q != WdogMax) begin
            wdog_d = wdog_q + 8'd1;
          end
        end
      end
      StAbort: begin
        state_d = StIdle;
        last_d  = owner_q;
        wdog_d  = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    case (state_d)
      StGrant0: grant_d = 2'b01;
      StGrant1: grant_d = 2'b10;
      default:  grant_d = 2'b00;
    endcase
    tevt_d = (state_d == StAbort);
  end

  // State register with synchronous reset; m1 marked last-served so m0 wins first.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= StIdle;
      wdog_q  <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      grant_q <= 2'b00;
      tevt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      tevt_q  <= tevt_d;
    end
  end

  // Slave bus mux: pass the owner's request through, else drive all zero.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (sel_m0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
    end else if (sel_m1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_cti_o = m1_cti_i;
      s_bte_o = m1_bte_i;
    end
  end

  // Response routing: only the owner sees the slave; abort injects err to the owner.
  always_comb begin
    m0_ack_o = sel_m0 & s_ack_i;
    m0_rty_o = sel_m0 & s_rty_i;
    m0_err_o = (sel_m0 & s_err_i) | (abort_act & ~owner_q);
    m0_dat_o = sel_m0 ? s_dat_i : '0;
    m1_ack_o = sel_m1 & s_ack_i;
    m1_rty_o = sel_m1 & s_rty_i;
    m1_err_o = (sel_m1 & s_err_i) | (abort_act & owner_q);
    m1_dat_o = sel_m1 ? s_dat_i : '0;
  end

  // Grant shows the bus owner; it reads 00 in ABORT because the bus is released.
  assign grant       = bus_en ? grant_q : 2'b00;
  assign timeout_evt = bus_en & tevt_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_wb_master_arbiter;

  localparam int W   = 32;
  localparam int TMO = 8;

  logic wb_clk = 1'b0;
  logic wb_rst;
  logic m0_cyc_i, m0_stb_i, m0_we_i;
  logic [W-1:0] m0_adr_i, m0_dat_i;
  logic [W/8-1:0] m0_sel_i;
  logic [2:0] m0_cti_i;
  logic [1:0] m0_bte_i;
  logic m0_ack_o, m0_err_o, m0_rty_o;
  logic [W-1:0] m0_dat_o;
  logic m1_cyc_i, m1_stb_i, m1_we_i;
  logic [W-1:0] m1_adr_i, m1_dat_i;
  logic [W/8-1:0] m1_sel_i;
  logic [2:0] m1_cti_i;
  logic [1:0] m1_bte_i;
  logic m1_ack_o, m1_err_o, m1_rty_o;
  logic [W-1:0] m1_dat_o;
  logic s_cyc_o, s_stb_o, s_we_o;
  logic [W-1:0] s_adr_o, s_dat_o;
  logic [W/8-1:0] s_sel_o;
  logic [2:0] s_cti_o;
  logic [1:0] s_bte_o;
  logic s_ack_i, s_err_i, s_rty_i;
  logic [W-1:0] s_dat_i;
  logic [1:0] grant;
  logic timeout_evt;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = bus free, 1 = owned, 2 = watchdog abort cycle.
  int md_mode  = 0;
  int md_own   = 0;
  int md_stall = 0;
  int md_last  = 1;

  wb_master_arbiter #(.WB_DATA(W), .TIMEOUT(TMO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
    .grant(grant), .timeout_evt(timeout_evt)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Compare every output against what the model says the bus should show now.
  task automatic check_outputs(input string tag);
    logic [75:0] e_bus, g_bus;
    logic [34:0] e_r0, e_r1, g_r0, g_r1;
    logic [1:0] e_g;
    logic e_t;
    e_bus = '0; e_r0 = '0; e_r1 = '0; e_g = 2'b00; e_t = 1'b0;
    if (wb_rst !== 1'b1) begin
      if (md_mode == 1 && md_own == 0) begin
        e_bus = {m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i, m0_cti_i, m0_bte_i};
        e_r0  = {s_ack_i, s_err_i, s_rty_i, s_dat_i};
        e_g   = 2'b01;
      end else if (md_mode == 1) begin
        e_bus = {m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i, m1_cti_i, m1_bte_i};
        e_r1  = {s_ack_i, s_err_i, s_rty_i, s_dat_i};
        e_g   = 2'b10;
      end else if (md_mode == 2) begin
        e_t = 1'b1;
        if (md_own == 0) e_r0[33] = 1'b1;
        else             e_r1[33] = 1'b1;
      end
    end
    g_bus = {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o};
    g_r0  = {m0_ack_o, m0_err_o, m0_rty_o, m0_dat_o};
    g_r1  = {m1_ack_o, m1_err_o, m1_rty_o, m1_dat_o};
    checks++;
    assert (g_bus === e_bus) else begin
      errors++; $error("FAIL %s.s_bus observed %h expected %h", tag, g_bus, e_bus);
    end
    checks++;
    assert (g_r0 === e_r0) else begin
      errors++; $error("FAIL %s.m0_resp observed %h expected %h", tag, g_r0, e_r0);
    end
    checks++;
    assert (g_r1 === e_r1) else begin
      errors++; $error("FAIL %s.m1_resp observed %h expected %h", tag, g_r1, e_r1);
    end
    checks++;
    assert (grant === e_g) else begin
      errors++; $error("FAIL %s.grant observed %b expected %b", tag, grant, e_g);
    end
    checks++;
    assert (timeout_evt === e_t) else begin
      errors++; $error("FAIL %s.timeout_evt observed %b expected %b", tag, timeout_evt, e_t);
    end
  endtask

  // Advance the model across one clock edge using the inputs seen at that edge.
  task automatic model_update();
    int c, s, t;
    if (wb_rst) begin
      md_mode = 0; md_stall = 0; md_last = 1;
    end else if (md_mode == 0) begin
      if (m0_cyc_i || m1_cyc_i) begin
        if (m0_cyc_i && m1_cyc_i) md_own = 1 - md_last;
        else                      md_own = m1_cyc_i ? 1 : 0;
        md_mode = 1; md_stall = 0;
      end
    end else if (md_mode == 1) begin
      c = (md_own == 1) ? int'(m1_cyc_i) : int'(m0_cyc_i);
      s = (md_own == 1) ? int'(m1_stb_i) : int'(m0_stb_i);
      t = int'(s_ack_i | s_err_i | s_rty_i);
      if (c == 0) begin
        md_mode = 0; md_last = md_own;
      end else if (t != 0) begin
        md_stall = 0;
      end else if (s != 0) begin
        md_stall++;
        if (md_stall >= TMO) md_mode = 2;
      end
    end else begin
      md_mode = 0; md_last = md_own;
    end
  endtask

  // One cycle: check at the falling edge, then step model with the rising edge.
  task automatic step(input string tag);
    @(negedge wb_clk);
    check_outputs(tag);
    @(posedge wb_clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0;
    m0_sel_i = '0; m0_cti_i = '0; m0_bte_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0;
    m1_sel_i = '0; m1_cti_i = '0; m1_bte_i = '0;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = '0;
  endtask

  initial begin
    int n_g, seen;
    logic [1:0] gseq [0:3];
    quiet();
    wb_rst = 1'b1;

    // Reset and first quiet cycles.
    step("reset0");
    step("reset1");
    wb_rst = 1'b0;
    step("post_reset");
    check_val("post_reset_grant", 32'(grant), 32'h0);

    // m0 alone: write 0x5 to 0x92000002, slave acks after three stalled cycles.
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 32'h9200_0002;
    m0_dat_i = 32'h5; m0_sel_i = 4'hF;
    step("m0_req");
    check_val("m0_grant_after_1", 32'(grant), 32'h1);
    step("m0_wait1");
    step("m0_wait2");
    step("m0_wait3");
    s_ack_i = 1; s_dat_i = 32'hCAFE_0001;
    step("m0_ack");
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    step("m0_drop");
    step("m0_idle");

    // Simultaneous requests: m0 first, one idle cycle, then m1, then m0 again.
    wb_rst = 1; step("rst_b"); wb_rst = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    m1_adr_i = 32'h1000_0040; m1_we_i = 0; m1_sel_i = 4'h3;
    step("both_req");
    gseq[0] = grant;
    s_ack_i = 1; step("both_m0_ack"); s_ack_i = 0;
    m0_cyc_i = 0; m0_stb_i = 0;
    step("m0_release");
    gseq[1] = grant;
    step("handover_idle");
    gseq[2] = grant;
    s_rty_i = 1; step("m1_rty"); s_rty_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0;
    step("m1_release");
    step("idle2");
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step("both_again");
    gseq[3] = grant;
    check_val("rr_first", 32'(gseq[0]), 32'h1);
    check_val("rr_idle_gap", 32'(gseq[1]), 32'h0);
    check_val("rr_second", 32'(gseq[2]), 32'h2);
    check_val("rr_third", 32'(gseq[3]), 32'h1);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step("rr_done");
    step("rr_idle");

    // m1 burst of four beats while m0 waits.
    m1_cyc_i = 1; m1_stb_i = 1; m1_cti_i = 3'b010; m1_bte_i = 2'b00;
    step("m1_burst_req");
    m0_cyc_i = 1; m0_stb_i = 1;
    for (int b = 0; b < 4; b++) begin
      s_ack_i = 1; s_dat_i = 32'hB000_0000 + 32'(b); m1_adr_i = 32'h2000_0000 + 32'(4 * b);
      if (b == 3) m1_cti_i = 3'b111;
      step("m1_burst_beat");
      check_val("burst_hold_grant", 32'(grant), 32'h2);
    end
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step("m1_burst_end");
    step("m0_after_burst");
    check_val("m0_after_burst_grant", 32'(grant), 32'h1);
    m0_cyc_i = 0; m0_stb_i = 0;
    step("burst_done");
    step("burst_idle");

    // Watchdog: slave silent, expect abort after TMO stalled cycles.
    m0_cyc_i = 1; m0_stb_i = 1;
    step("tmo_req");
    n_g = 0; seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      if (grant == 2'b01) n_g++;
      step("tmo_wait");
      if (timeout_evt === 1'b1) begin
        seen = 1;
        check_val("tmo_err", 32'(m0_err_o), 32'h1);
        check_val("tmo_scyc", 32'(s_cyc_o), 32'h0);
        m0_cyc_i = 0; m0_stb_i = 0;
      end
    end
    check_val("tmo_seen", 32'(seen), 32'h1);
    check_val("tmo_stall_cycles", 32'(n_g), 32'(TMO));
    step("tmo_abort");
    step("tmo_idle");

    // Ack arriving on the expiry cycle cancels the abort.
    m0_cyc_i = 1; m0_stb_i = 1;
    step("edge_req");
    for (int k = 0; k < TMO - 1; k++) step("edge_stall");
    s_ack_i = 1;
    step("edge_ack");
    s_ack_i = 0;
    check_val("edge_no_tevt", 32'(timeout_evt), 32'h0);
    check_val("edge_still_granted", 32'(grant), 32'h1);
    step("edge_cont");

    // Cyc drop on the expiry cycle wins over the abort.
    m0_cyc_i = 0; m0_stb_i = 0;
    step("drop_rel");
    step("drop_idle");
    m0_cyc_i = 1; m0_stb_i = 1;
    step("drop_req");
    for (int k = 0; k < TMO - 1; k++) step("drop_stall");
    m0_cyc_i = 0;
    step("drop_expiry");
    check_val("drop_no_tevt", 32'(timeout_evt), 32'h0);
    check_val("drop_no_err", 32'(m0_err_o), 32'h0);
    m0_stb_i = 0;
    step("drop_idle2");

    // Reset pulsed mid-burst on m1.
    m1_cyc_i = 1; m1_stb_i = 1; m1_cti_i = 3'b010;
    step("rstb_req");
    s_ack_i = 1;
    step("rstb_beat");
    wb_rst = 1;
    step("rstb_reset");
    wb_rst = 0;
    check_val("rstb_grant", 32'(grant), 32'h0);
    check_val("rstb_scyc", 32'(s_cyc_o), 32'h0);
    check_val("rstb_m1_term", 32'({m1_ack_o, m1_err_o, m1_rty_o}), 32'h0);
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step("rstb_after");

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if (m0_cyc_i) m0_cyc_i = ($urandom_range(0, 7) != 0);
      else          m0_cyc_i = ($urandom_range(0, 3) == 0);
      if (m1_cyc_i) m1_cyc_i = ($urandom_range(0, 7) != 0);
      else          m1_cyc_i = ($urandom_range(0, 3) == 0);
      m0_stb_i = m0_cyc_i & ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i & ($urandom_range(0, 3) != 0);
      m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
      m0_adr_i = $urandom; m0_dat_i = $urandom; m1_adr_i = $urandom; m1_dat_i = $urandom;
      m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
      m0_cti_i = 3'($urandom); m1_cti_i = 3'($urandom);
      m0_bte_i = 2'($urandom); m1_bte_i = 2'($urandom);
      s_ack_i = ($urandom_range(0, 5) == 0);
      s_err_i = ($urandom_range(0, 29) == 0);
      s_rty_i = ($urandom_range(0, 29) == 0);
      s_dat_i = $urandom;
      wb_rst = ($urandom_range(0, 199) == 0);
      step("rand");
    end
    wb_rst = 0;
    quiet();
    step("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
